// File: rtl/mpi_pkg.sv
// Shared types and constants for the MPI-bus master: state encoding and
// low-true bus level names.
package mpi_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_SYNC    = 3'd2,
        S_DATA    = 3'd3,
        S_STROBE  = 3'd4,
        S_RELEASE = 3'd5,
        S_END     = 3'd6
    } state_t;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    localparam int          DEFAULT_TIMEOUT = 64;
    localparam logic [15:0] AD_RELEASED     = 16'hFFFF;

endpackage

// File: rtl/mpi_sync2.sv
// Two-flop synchronizer with asynchronous reset to a configurable level,
// used to bring the slave reply line into the clk domain.
module mpi_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mpi_bus_master.sv
// MPI-bus master sequencer: turns single-word requests into complete
// address/data/strobe/reply bus cycles with a reply timeout.
module mpi_bus_master
    import mpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int HOLD_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    input  logic [15:0] nAD_in,
    output logic [15:0] nAD_out,
    output logic        nAD_oe,
    output logic        nSYNC,
    output logic        nDIN,
    output logic        nDOUT,
    output logic        nWTBT,
    output logic        nBSY,
    input  logic        nRPLY
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] tcnt;
    logic [HW-1:0] hcnt;
    logic          rply_s;
    logic          hold_done;
    logic          t_expired;
    logic          accept;

    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic          write_q;
    logic          byte_q;
    logic          flag_q;

    mpi_sync2 #(.RESET_VALUE(INACTIVE)) u_rply_sync (
        .clk (clk),
        .rst (rst),
        .d   (nRPLY),
        .q   (rply_s)
    );

    assign accept    = req_valid && (state == S_IDLE);
    assign hold_done = (hcnt == HW'(HOLD_CYCLES - 1));
    assign t_expired = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (req_valid) state_next = S_ADDR;
            S_ADDR:    if (hold_done) state_next = S_SYNC;
            S_SYNC:    state_next = S_DATA;
            S_DATA:    if (hold_done) state_next = S_STROBE;
            S_STROBE:  if (!rply_s || t_expired) state_next = S_RELEASE;
            S_RELEASE: if (rply_s || t_expired) state_next = S_END;
            S_END:     state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Both counters restart on every state change; tcnt saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            tcnt <= '0;
        end else if (state_next != state) begin
            hcnt <= '0;
            tcnt <= '0;
        end else begin
            if (state == S_ADDR || state == S_DATA) hcnt <= hcnt + 1'b1;
            if (tcnt != TW'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            byte_q      <= 1'b0;
            flag_q      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid   <= (state == S_END);
            rsp_timeout <= (state == S_END) && flag_q;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                write_q <= req_write;
                byte_q  <= req_byte;
                flag_q  <= 1'b0;
            end
            if (state == S_STROBE) begin
                if (!rply_s) begin
                    if (!write_q) rsp_rdata <= ~nAD_in;
                end else if (t_expired) begin
                    flag_q    <= 1'b1;
                    rsp_rdata <= '0;
                end
            end
            if (state == S_RELEASE && !rply_s && t_expired) flag_q <= 1'b1;
        end
    end

    // Bus pins decode from state only, so an async reset releases them at once.
    always_comb begin
        req_ready = 1'b0;
        nAD_oe    = 1'b0;
        nAD_out   = AD_RELEASED;
        nSYNC     = INACTIVE;
        nDIN      = INACTIVE;
        nDOUT     = INACTIVE;
        nWTBT     = INACTIVE;
        nBSY      = INACTIVE;
        case (state)
            S_IDLE: req_ready = 1'b1;
            S_ADDR, S_SYNC: begin
                nBSY    = ACTIVE;
                nAD_oe  = 1'b1;
                nAD_out = ~addr_q;
                nWTBT   = ~write_q;
                if (state == S_SYNC) nSYNC = ACTIVE;
            end
            S_DATA, S_STROBE: begin
                nBSY  = ACTIVE;
                nSYNC = ACTIVE;
                if (write_q) begin
                    nAD_oe  = 1'b1;
                    nAD_out = ~wdata_q;
                    nWTBT   = ~byte_q;
                end
                if (state == S_STROBE) begin
                    if (write_q) nDOUT = ACTIVE;
                    else         nDIN  = ACTIVE;
                end
            end
            S_RELEASE: begin
                nBSY  = ACTIVE;
                nSYNC = ACTIVE;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mpi_bus_master.sv
// Directed bench for mpi_bus_master with a simple bus responder model.
module tb_mpi_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_timeout;
    logic [15:0] nAD_in = 16'hFFFF;
    logic [15:0] nAD_out;
    logic        nAD_oe;
    logic        nSYNC, nDIN, nDOUT, nWTBT, nBSY;
    logic        nRPLY = 1'b1;

    int tests = 0;
    int failures = 0;

    mpi_bus_master #(.TIMEOUT_CYCLES(16), .HOLD_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .nAD_in(nAD_in), .nAD_out(nAD_out), .nAD_oe(nAD_oe),
        .nSYNC(nSYNC), .nDIN(nDIN), .nDOUT(nDOUT), .nWTBT(nWTBT), .nBSY(nBSY),
        .nRPLY(nRPLY)
    );

    always #5 clk = ~clk;

    // Responder: reply 3 cycles into a strobe, release 2 cycles after it ends.
    logic        resp_en = 1'b0;
    logic        resp_stuck = 1'b0;
    logic [15:0] resp_bus = 16'h5A5A;
    int          str_cnt = 0;
    int          rel_cnt = 0;

    always @(negedge clk) begin
        if (resp_stuck) begin
            nRPLY = 1'b0;
        end else if (!resp_en) begin
            nRPLY = 1'b1; nAD_in = 16'hFFFF; str_cnt = 0; rel_cnt = 0;
        end else if (!nDIN || !nDOUT) begin
            rel_cnt = 0;
            str_cnt++;
            if (str_cnt >= 3) begin
                nRPLY = 1'b0;
                if (!nDIN) nAD_in = resp_bus;
            end
        end else begin
            str_cnt = 0;
            if (!nRPLY) begin
                rel_cnt++;
                if (rel_cnt >= 2) begin nRPLY = 1'b1; nAD_in = 16'hFFFF; end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
        int got;
        req_write = w; req_byte = b; req_addr = a; req_wdata = d; req_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin got = 1; break; end
            @(negedge clk);
        end
        check("accept", 32'(got), 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    logic        wtbt_a, wtbt_d, seen_a, oe_bad, both_bad, tmo, rdy_at_rv, prev_sync;
    logic [15:0] sync_addr, dout_data, rdata;
    int          dout_cnt, din_cnt, rv_cnt, tail;

    task automatic observe();
        wtbt_a = 1'bx; wtbt_d = 1'bx; seen_a = 1'b0; oe_bad = 1'b0; both_bad = 1'b0;
        tmo = 1'bx; rdy_at_rv = 1'bx; prev_sync = 1'b1;
        sync_addr = 'x; dout_data = 'x; rdata = 'x;
        dout_cnt = 0; din_cnt = 0; rv_cnt = 0; tail = 0;
        for (int i = 0; i < 100; i++) begin
            if (!nBSY && !seen_a) begin wtbt_a = nWTBT; seen_a = 1'b1; end
            if (!nSYNC && prev_sync) sync_addr = nAD_out;
            prev_sync = nSYNC;
            if (!nDOUT) begin dout_cnt++; dout_data = nAD_out; wtbt_d = nWTBT; end
            if (!nDIN) begin din_cnt++; wtbt_d = nWTBT; if (nAD_oe) oe_bad = 1'b1; end
            if (!nDIN && !nDOUT) both_bad = 1'b1;
            if (rsp_valid) begin rv_cnt++; tmo = rsp_timeout; rdata = rsp_rdata; rdy_at_rv = req_ready; end
            if (rv_cnt > 0) tail++;
            if (tail == 3) break;
            @(negedge clk);
        end
        check("rsp_count", 32'(rv_cnt), 1);
        check("strobe_overlap", 32'(both_bad), 0);
        check("ready_with_rsp", 32'(rdy_at_rv), 1);
    endtask

    int          got, rv, acc, falls, hi_run, gap, rvs;
    logic        acc2_rv, changed, drop, prev;
    logic [15:0] a1, a2, d1, d2;

    initial begin
        // Reset state
        #1;
        check("rst_bus", 32'({nSYNC, nDIN, nDOUT, nWTBT, nBSY, nAD_oe}), 32'h3E);
        check("rst_ad", 32'(nAD_out), 32'hFFFF);
        check("rst_rsp", 32'({req_ready, rsp_valid, rsp_timeout}), 32'h4);
        check("rst_rdata", 32'(rsp_rdata), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Word write
        resp_en = 1'b1;
        issue(1'b1, 1'b0, 16'hFFCC, 16'h1234);
        observe();
        check("ww_sync_addr", 32'(sync_addr), 32'h0033);
        check("ww_data", 32'(dout_data), 32'hEDCB);
        check("ww_wtbt_addr", 32'(wtbt_a), 0);
        check("ww_wtbt_data", 32'(wtbt_d), 1);
        check("ww_timeout", 32'(tmo), 0);

        // Word read
        resp_bus = 16'h5A5A;
        issue(1'b0, 1'b0, 16'hFFCC, 16'h0000);
        observe();
        check("rd_sync_addr", 32'(sync_addr), 32'h0033);
        check("rd_wtbt_addr", 32'(wtbt_a), 1);
        check("rd_din_seen", 32'(din_cnt > 0), 1);
        check("rd_oe_in_din", 32'(oe_bad), 0);
        check("rd_data", 32'(rdata), 32'hA5A5);
        check("rd_timeout", 32'(tmo), 0);

        // Byte write
        issue(1'b1, 1'b1, 16'hFFCD, 16'hAB00);
        observe();
        check("bw_sync_addr", 32'(sync_addr), 32'h0032);
        check("bw_wtbt_addr", 32'(wtbt_a), 0);
        check("bw_wtbt_data", 32'(wtbt_d), 0);
        check("bw_data", 32'(dout_data), 32'h54FF);

        // Timeouts with no responder
        resp_en = 1'b0;
        issue(1'b1, 1'b0, 16'h0200, 16'h5555);
        observe();
        check("to_w_dout_cycles", 32'(dout_cnt), 16);
        check("to_w_timeout", 32'(tmo), 1);
        issue(1'b0, 1'b0, 16'h0202, 16'h0000);
        observe();
        check("to_r_din_cycles", 32'(din_cnt), 16);
        check("to_r_timeout", 32'(tmo), 1);
        check("to_r_rdata", 32'(rdata), 0);

        // Stuck-low reply: accepted at once, then release times out
        resp_stuck = 1'b1;
        repeat (3) @(negedge clk);
        issue(1'b1, 1'b0, 16'h0100, 16'h00FF);
        observe();
        check("stuck_dout_cycles", 32'(dout_cnt), 1);
        check("stuck_timeout", 32'(tmo), 1);
        resp_stuck = 1'b0;
        repeat (4) @(negedge clk);

        // Reset while the read strobe is active
        issue(1'b0, 1'b0, 16'hFFCC, 16'h0000);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (!nDIN) begin got = 1; break; end
            @(negedge clk);
        end
        check("din_reached", 32'(got), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_bus", 32'({nSYNC, nDIN, nDOUT, nWTBT, nBSY, nAD_oe}), 32'h3E);
        check("mid_rst_ad", 32'(nAD_out), 32'hFFFF);
        check("mid_rst_rv", 32'(rsp_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 1);
        rv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) rv++;
        end
        check("post_rst_no_rsp", 32'(rv), 0);

        // Back-to-back with req_valid held and fields changed mid-cycle
        resp_en = 1'b1;
        req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h1000; req_wdata = 16'h1111;
        req_valid = 1'b1;
        acc = 0; falls = 0; hi_run = 0; gap = -1; rvs = 0;
        acc2_rv = 1'b0; changed = 1'b0; drop = 1'b0; prev = 1'b1;
        a1 = 'x; a2 = 'x; d1 = 'x; d2 = 'x;
        for (int i = 0; i < 150; i++) begin
            if (drop) begin req_valid = 1'b0; drop = 1'b0; end
            if (req_valid && req_ready) begin
                acc++;
                if (acc == 2) begin acc2_rv = rsp_valid; drop = 1'b1; end
            end
            if (nSYNC) hi_run++;
            if (!nSYNC && prev) begin
                falls++;
                if (falls == 1) a1 = nAD_out;
                else begin a2 = nAD_out; gap = hi_run; end
            end
            if (!nSYNC) hi_run = 0;
            prev = nSYNC;
            if (!nDOUT) begin
                if (falls == 1) d1 = nAD_out;
                else d2 = nAD_out;
            end
            if (falls == 1 && !nSYNC && !changed) begin
                req_addr = 16'h2000; req_wdata = 16'h2222; changed = 1'b1;
            end
            if (rsp_valid) rvs++;
            if (rvs == 2) break;
            @(negedge clk);
        end
        check("b2b_rsp_count", 32'(rvs), 2);
        check("b2b_accepts", 32'(acc), 2);
        check("b2b_accept_with_rsp", 32'(acc2_rv), 1);
        check("b2b_sync_gap", 32'(gap), 3);
        check("b2b_addr1", 32'(a1), 32'hEFFF);
        check("b2b_data1", 32'(d1), 32'hEEEE);
        check("b2b_addr2", 32'(a2), 32'hDFFF);
        check("b2b_data2", 32'(d2), 32'hDDDD);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
